// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: reads operand pairs, hands them to an external 8x8 multiplier, writes products back.
// Optional CALC watchdog compiled in with `define MUL_SEQ_TIMEOUT_EN.
module mul_seq_ctrl #(
    parameter int AW           = 8,
    parameter int N_PAIRS      = 15,
    parameter int SRC_BASE     = 0,
    parameter int DST_BASE     = 30,
    parameter int CALC_TIMEOUT = 64
) (
    input  logic          CLK,
    input  logic          start,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [7:0]    mem_din,
    input  logic [7:0]    mem_dout,
    output logic [7:0]    opA,
    output logic [7:0]    opB,
    output logic          calc_req,
    input  logic          calc_ack,
    input  logic [7:0]    res_msw,
    input  logic [7:0]    res_lsw,
    output logic [7:0]    pair_ct,
    output logic          halt,
    output logic          err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_A   = 3'd1,
        RD_B   = 3'd2,
        CALC   = 3'd3,
        WR_MSW = 3'd4,
        WR_LSW = 3'd5,
        DONE   = 3'd6
    } state_t;

    localparam logic [AW-1:0] SRC  = AW'(SRC_BASE);
    localparam logic [AW-1:0] DST  = AW'(DST_BASE);
    localparam logic [7:0]    LAST = 8'(N_PAIRS - 1);

    state_t     state;
    logic [7:0] lsw_q;

    // base + 2*idx + odd, wrapping modulo 2^AW
    function automatic logic [AW-1:0] addr_of(input logic [AW-1:0] base,
                                              input logic [7:0]    idx,
                                              input logic          odd);
        return base + AW'({idx, odd});
    endfunction

`ifdef MUL_SEQ_TIMEOUT_EN
    localparam int            TW      = $clog2(CALC_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(CALC_TIMEOUT - 1);

    logic [TW-1:0] calc_cnt;
    logic          err_q;

    assign err = err_q;
`else
    // Without the watchdog no legal CALC_TIMEOUT can raise err.
    assign err = (CALC_TIMEOUT < 0);
`endif

    // Outputs are loaded on the transition into the state that owns them.
    always_ff @(posedge CLK or posedge start) begin
        if (start) begin
            state    <= IDLE;
            mem_addr <= '0;
            mem_rd   <= 1'b0;
            mem_wr   <= 1'b0;
            mem_din  <= '0;
            opA      <= '0;
            opB      <= '0;
            calc_req <= 1'b0;
            pair_ct  <= '0;
            halt     <= 1'b0;
            lsw_q    <= '0;
`ifdef MUL_SEQ_TIMEOUT_EN
            calc_cnt <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            mem_rd   <= 1'b0;
            mem_wr   <= 1'b0;
            calc_req <= 1'b0;
            case (state)
                IDLE: begin
                    if (N_PAIRS == 0) begin
                        state <= DONE;
                        halt  <= 1'b1;
                    end else begin
                        state    <= RD_A;
                        mem_addr <= addr_of(SRC, pair_ct, 1'b0);
                        mem_rd   <= 1'b1;
                    end
                end
                RD_A: begin
                    opA      <= mem_dout;
                    state    <= RD_B;
                    mem_addr <= addr_of(SRC, pair_ct, 1'b1);
                    mem_rd   <= 1'b1;
                end
                RD_B: begin
                    opB      <= mem_dout;
                    state    <= CALC;
                    calc_req <= 1'b1;
`ifdef MUL_SEQ_TIMEOUT_EN
                    calc_cnt <= '0;
`endif
                end
                CALC: begin
                    if (calc_ack) begin
                        lsw_q    <= res_lsw;
                        mem_din  <= res_msw;
                        state    <= WR_MSW;
                        mem_addr <= addr_of(DST, pair_ct, 1'b0);
                        mem_wr   <= 1'b1;
                    end
`ifdef MUL_SEQ_TIMEOUT_EN
                    else if (calc_cnt == TO_LAST) begin
                        state <= DONE;
                        halt  <= 1'b1;
                        err_q <= 1'b1;
                    end else begin
                        calc_req <= 1'b1;
                        calc_cnt <= calc_cnt + 1'b1;
                    end
`else
                    else begin
                        calc_req <= 1'b1;
                    end
`endif
                end
                WR_MSW: begin
                    mem_din  <= lsw_q;
                    state    <= WR_LSW;
                    mem_addr <= addr_of(DST, pair_ct, 1'b1);
                    mem_wr   <= 1'b1;
                end
                WR_LSW: begin
                    if (pair_ct == LAST) begin
                        state <= DONE;
                        halt  <= 1'b1;
                    end else begin
                        pair_ct  <= pair_ct + 8'd1;
                        state    <= RD_A;
                        mem_addr <= addr_of(SRC, pair_ct + 8'd1, 1'b0);
                        mem_rd   <= 1'b1;
                    end
                end
                DONE:    state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Bench for mul_seq_ctrl: memory model, multiplier stub, read/write scoreboard.
// dut0 exercises wrap-around sourcing (SRC_BASE=254, 2 pairs); dut1 covers N_PAIRS=0.
module tb_mul_seq_ctrl;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // dut0 signals
    logic       start0 = 1'b1;
    logic [7:0] addr0, din0, dout0, opA0, opB0, pct0;
    logic       rd0, wr0, req0, halt0, err0;
    logic       ack0 = 1'b0;
    logic [7:0] msw0 = 8'h00, lsw0 = 8'h00;

    // dut1 signals
    logic       start1 = 1'b1;
    logic [7:0] addr1, din1, opA1, opB1, pct1;
    logic       rd1, wr1, req1, halt1, err1;

    // memory model for dut0, preloaded through the ld_* port while in reset
    logic [7:0] mem [256];
    logic       ld_en = 1'b0;
    logic [7:0] ld_addr = 8'h00, ld_data = 8'h00;
    assign dout0 = mem[addr0];
    always @(posedge CLK) begin
        if (wr0)        mem[addr0]   <= din0;
        else if (ld_en) mem[ld_addr] <= ld_data;
    end

    int edges = 0;
    always @(posedge CLK) begin
        if (start0) edges <= 0;
        else        edges <= edges + 1;
    end

    // multiplier stub: ack in the k_sel-th CALC cycle, optional spurious acks when idle
    int k_sel   = 1;
    bit no_ack  = 1'b0;
    bit spur_en = 1'b0;
    int ccnt    = 0;
    always @(negedge CLK) begin
        if (req0 && !no_ack) begin
            ccnt = ccnt + 1;
            ack0 = (ccnt == k_sel);
            {msw0, lsw0} = 16'(opA0) * 16'(opB0);
        end else begin
            ccnt = 0;
            ack0 = spur_en && !req0;
            {msw0, lsw0} = 16'hA5A5;
        end
    end

    mul_seq_ctrl #(.AW(8), .N_PAIRS(2), .SRC_BASE(254), .DST_BASE(30), .CALC_TIMEOUT(8)) dut0 (
        .CLK(CLK), .start(start0), .mem_addr(addr0), .mem_rd(rd0), .mem_wr(wr0),
        .mem_din(din0), .mem_dout(dout0), .opA(opA0), .opB(opB0), .calc_req(req0),
        .calc_ack(ack0), .res_msw(msw0), .res_lsw(lsw0), .pair_ct(pct0),
        .halt(halt0), .err(err0)
    );

    mul_seq_ctrl #(.AW(8), .N_PAIRS(0), .SRC_BASE(0), .DST_BASE(30), .CALC_TIMEOUT(8)) dut1 (
        .CLK(CLK), .start(start1), .mem_addr(addr1), .mem_rd(rd1), .mem_wr(wr1),
        .mem_din(din1), .mem_dout(8'h00), .opA(opA1), .opB(opB1), .calc_req(req1),
        .calc_ack(1'b0), .res_msw(8'h00), .res_lsw(8'h00), .pair_ct(pct1),
        .halt(halt1), .err(err1)
    );

    // scoreboard
    logic [7:0]  rd_q[$];
    logic [15:0] wr_q[$];
    int rd_cnt = 0, wr_cnt = 0, rd1_cnt = 0, wr1_cnt = 0;

    // Advance to the next negedge and score whatever dut0 drives in that cycle.
    task automatic tick();
        logic [7:0]  ea;
        logic [15:0] ew;
        @(negedge CLK);
        if (!start0) begin
            checks++;
            if (rd0 && wr0) begin
                failures++;
                $display("FAIL rd_wr_exclusive got rd=%b wr=%b want not both", rd0, wr0);
            end
            if (rd0) begin
                rd_cnt++;
                checks++;
                if (rd_q.size() == 0) begin
                    failures++;
                    $display("FAIL rd_unexpected got addr=%0d want no read", addr0);
                end else begin
                    ea = rd_q.pop_front();
                    if (addr0 !== ea) begin
                        failures++;
                        $display("FAIL rd_addr got=%0d want=%0d", addr0, ea);
                    end
                end
            end
            if (wr0) begin
                wr_cnt++;
                checks++;
                if (wr_q.size() == 0) begin
                    failures++;
                    $display("FAIL wr_unexpected got addr=%0d data=%h want no write", addr0, din0);
                end else begin
                    ew = wr_q.pop_front();
                    if ({addr0, din0} !== ew) begin
                        failures++;
                        $display("FAIL wr_data got addr=%0d data=%h want addr=%0d data=%h",
                                 addr0, din0, ew[15:8], ew[7:0]);
                    end
                end
            end
        end
        if (rd1) rd1_cnt++;
        if (wr1) wr1_cnt++;
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        ld_addr = a;
        ld_data = d;
        ld_en   = 1'b1;
        @(posedge CLK);
        #1 ld_en = 1'b0;
    endtask

    // Hold dut0 in reset, preload pairs, queue the expected reads and writes.
    task automatic load(input logic [7:0] a0, input logic [7:0] b0,
                        input logic [7:0] a1, input logic [7:0] b1, input int k);
        logic [15:0] p0, p1;
        start0 = 1'b1;
        k_sel  = k;
        poke(8'd254, a0);
        poke(8'd255, b0);
        poke(8'd0, a1);
        poke(8'd1, b1);
        for (int i = 30; i < 34; i++) poke(8'(i), 8'h5A);
        rd_q.delete();
        wr_q.delete();
        rd_cnt = 0;
        wr_cnt = 0;
        rd_q.push_back(8'd254);
        rd_q.push_back(8'd255);
        rd_q.push_back(8'd0);
        rd_q.push_back(8'd1);
        p0 = 16'(a0) * 16'(b0);
        p1 = 16'(a1) * 16'(b1);
        wr_q.push_back({8'd30, p0[15:8]});
        wr_q.push_back({8'd31, p0[7:0]});
        wr_q.push_back({8'd32, p1[15:8]});
        wr_q.push_back({8'd33, p1[7:0]});
        tick();
    endtask

    task automatic wait_halt(input int budget, output bit seen);
        seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            tick();
            if (halt0) seen = 1'b1;
        end
    endtask

    // Full two-pair run with ack delay k; checks halt edge, traffic and final memory.
    task automatic run_pairs(input string name, input logic [7:0] a0, input logic [7:0] b0,
                             input logic [7:0] a1, input logic [7:0] b1, input int k,
                             input int exp_edge, input logic [31:0] exp_mem);
        bit seen;
        load(a0, b0, a1, b1, k);
        start0 = 1'b0;
        wait_halt(300, seen);
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s_halt_timeout got halt=0 want halt=1", name);
        end else if (edges !== exp_edge) begin
            failures++;
            $display("FAIL %s_halt_edge got=%0d want=%0d", name, edges, exp_edge);
        end
        checks++;
        if (wr_cnt !== 4 || rd_cnt !== 4 || wr_q.size() != 0 || rd_q.size() != 0) begin
            failures++;
            $display("FAIL %s_traffic got wr=%0d rd=%0d want wr=4 rd=4", name, wr_cnt, rd_cnt);
        end
        checks++;
        if ({mem[30], mem[31], mem[32], mem[33]} !== exp_mem) begin
            failures++;
            $display("FAIL %s_mem got=%h want=%h", name, {mem[30], mem[31], mem[32], mem[33]}, exp_mem);
        end
        checks++;
        if (err0 !== 1'b0 || pct0 !== 8'd1 || req0 !== 1'b0) begin
            failures++;
            $display("FAIL %s_final got err=%b pair_ct=%0d req=%b want err=0 pair_ct=1 req=0",
                     name, err0, pct0, req0);
        end
    endtask

    task automatic test_reset();
        start0 = 1'b1;
        start1 = 1'b1;
        tick();
        tick();
        checks++;
        if ({addr0, din0, pct0} !== 24'h0) begin
            failures++;
            $display("FAIL reset_regs got addr=%h din=%h pair_ct=%h want 0", addr0, din0, pct0);
        end
        checks++;
        if ({opA0, opB0} !== 16'h0) begin
            failures++;
            $display("FAIL reset_ops got opA=%h opB=%h want 0", opA0, opB0);
        end
        checks++;
        if ({rd0, wr0, req0, halt0, err0} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got rd,wr,req,halt,err=%b want 00000",
                     {rd0, wr0, req0, halt0, err0});
        end
    endtask

    task automatic test_basic();
        run_pairs("basic", 8'd3, 8'd5, 8'h10, 8'h20, 1, 11, 32'h000F_0200);
    endtask

    task automatic test_slow_ack();
        run_pairs("slow", 8'hFF, 8'hFF, 8'h10, 8'h10, 3, 15, 32'hFE01_0100);
    endtask

    task automatic test_reset_mid();
        bit seen;
        // reset while the second pair sits in CALC
        load(8'd2, 8'd3, 8'd4, 8'd5, 6);
        start0 = 1'b0;
        for (int c = 0; c < 100 && !(req0 && pct0 == 8'd1); c++) tick();
        checks++;
        if (!(req0 && pct0 == 8'd1)) begin
            failures++;
            $display("FAIL mid_reach_calc got req=%b pair_ct=%0d want req=1 pair_ct=1", req0, pct0);
        end
        start0 = 1'b1;
        #1;
        checks++;
        if ({req0, wr0, pct0} !== 10'h0) begin
            failures++;
            $display("FAIL mid_async_clear got req=%b wr=%b pair_ct=%0d want 0", req0, wr0, pct0);
        end
        // restart must re-read from SRC_BASE and complete normally
        load(8'd2, 8'd3, 8'd4, 8'd5, 6);
        start0 = 1'b0;
        wait_halt(300, seen);
        checks++;
        if (!seen || edges !== 21) begin
            failures++;
            $display("FAIL mid_restart_halt got seen=%b edge=%0d want seen=1 edge=21", seen, edges);
        end
        checks++;
        if (wr_cnt !== 4 || rd_cnt !== 4 || {mem[30], mem[31], mem[32], mem[33]} !== 32'h0006_0014) begin
            failures++;
            $display("FAIL mid_restart_result got wr=%0d rd=%0d mem=%h want wr=4 rd=4 mem=00060014",
                     wr_cnt, rd_cnt, {mem[30], mem[31], mem[32], mem[33]});
        end
        // reset while the first MSW write is on the bus: the write must not land
        load(8'd9, 8'd9, 8'd1, 8'd1, 1);
        start0 = 1'b0;
        for (int c = 0; c < 100 && !wr0; c++) tick();
        start0 = 1'b1;
        #1;
        checks++;
        if (wr0 !== 1'b0) begin
            failures++;
            $display("FAIL mid_wr_drop got wr=%b want 0", wr0);
        end
        tick();
        checks++;
        if (mem[30] !== 8'h5A) begin
            failures++;
            $display("FAIL mid_wr_landed got mem30=%h want 5a", mem[30]);
        end
    endtask

    task automatic test_spurious_ack();
        run_pairs("spur", 8'd7, 8'd9, 8'd200, 8'd3, 2, 13, 32'h003F_0258);
        spur_en = 1'b1;
        run_pairs("spur_on", 8'd7, 8'd9, 8'd200, 8'd3, 2, 13, 32'h003F_0258);
        for (int c = 0; c < 10; c++) tick();
        checks++;
        if (halt0 !== 1'b1 || wr_cnt !== 4 || req0 !== 1'b0 || pct0 !== 8'd1) begin
            failures++;
            $display("FAIL spur_done_stable got halt=%b wr=%0d req=%b pair_ct=%0d want 1 4 0 1",
                     halt0, wr_cnt, req0, pct0);
        end
        spur_en = 1'b0;
    endtask

    task automatic test_n_pairs_zero();
        start1 = 1'b1;
        tick();
        tick();
        rd1_cnt = 0;
        wr1_cnt = 0;
        start1  = 1'b0;
        checks++;
        if (halt1 !== 1'b0) begin
            failures++;
            $display("FAIL npz_pre_edge got halt=%b want 0", halt1);
        end
        tick();
        checks++;
        if (halt1 !== 1'b1) begin
            failures++;
            $display("FAIL npz_halt_edge1 got halt=%b want 1", halt1);
        end
        for (int c = 0; c < 5; c++) tick();
        checks++;
        if (rd1_cnt !== 0 || wr1_cnt !== 0 || err1 !== 1'b0) begin
            failures++;
            $display("FAIL npz_traffic got rd=%0d wr=%0d err=%b want 0 0 0", rd1_cnt, wr1_cnt, err1);
        end
    endtask

    task automatic test_timeout();
        bit seen;
        load(8'd1, 8'd1, 8'd1, 8'd1, 1);
        no_ack = 1'b1;
        wr_q.delete();
        rd_q.delete();
        rd_q.push_back(8'd254);
        rd_q.push_back(8'd255);
        start0 = 1'b0;
`ifdef MUL_SEQ_TIMEOUT_EN
        wait_halt(100, seen);
        checks++;
        if (!seen || edges !== 11) begin
            failures++;
            $display("FAIL timeout_halt got seen=%b edge=%0d want seen=1 edge=11", seen, edges);
        end
        checks++;
        if (err0 !== 1'b1) begin
            failures++;
            $display("FAIL timeout_err got=%b want 1", err0);
        end
`else
        wait_halt(1000, seen);
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL timeout_no_halt got halt=1 want halt=0 for 1000 cycles");
        end
        checks++;
        if (err0 !== 1'b0 || req0 !== 1'b1) begin
            failures++;
            $display("FAIL timeout_wait got err=%b req=%b want err=0 req=1", err0, req0);
        end
`endif
        checks++;
        if (wr_cnt !== 0 || rd_cnt !== 2) begin
            failures++;
            $display("FAIL timeout_traffic got wr=%0d rd=%0d want wr=0 rd=2", wr_cnt, rd_cnt);
        end
        no_ack = 1'b0;
        start0 = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_slow_ack();
        test_reset_mid();
        test_spurious_ack();
        test_n_pairs_zero();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_seq_ctrl.md
# mul_seq_ctrl

Sequencer that drives the 8-bit data memory and an external 8x8 multiplier to batch-process operand pairs. It reads each operand pair from a source region, hands it to the multiplier over a req/ack handshake, and writes the 16-bit product back as MSW then LSW to a destination region. It then asserts `halt`. It sits beside `data_mem` in the processor top level and owns the memory address, read-enable and write-enable lines while running.

## Interface
- `AW`, 8: data-memory address width.
- `N_PAIRS`, 15: number of operand pairs to process (0..255).
- `SRC_BASE`, 0: address of the first operand A; operand B is at A+1.
- `DST_BASE`, 30: address of the first product MSW; LSW is at MSW+1.
- `CALC_TIMEOUT`, 64: maximum number of CALC cycles; used only when `MUL_SEQ_TIMEOUT_EN` is defined.

Ports:
- `CLK`  in  1  clock; posedge only.
- `start`  in  1  reset, asynchronous, active-high.
- `mem_addr`  out  AW  data-memory address.
- `mem_rd`  out  1  read enable.
- `mem_wr`  out  1  write enable.
- `mem_din`  out  8  write data.
- `mem_dout`  in  8  read data; combinational read.
- `opA`, `opB`  out  8 each  latched operands to the multiplier.
- `calc_req`  out  1  multiply request.
- `calc_ack`  in  1  one-cycle pulse; `res_msw`/`res_lsw` are valid in that cycle.
- `res_msw`, `res_lsw`  in  8 each  product halves.
- `pair_ct`  out  8  index of the current pair.
- `halt`  out  1  done; sticky until reset.
- `err`  out  1  timeout flag; sticky.

## Operation
- States: IDLE, RD_A, RD_B, CALC, WR_MSW, WR_LSW, DONE. State is fully encoded and registered.
- IDLE:
  - Lasts one cycle after reset release.
  - Goes to RD_A, or to DONE if `N_PAIRS`==0.
- RD_A:
  - `mem_addr`=SRC_BASE+2*i, `mem_rd`=1.
  - Latches `mem_dout` into `opA` at the cycle-ending edge.
  - Goes to RD_B.
- RD_B:
  - `mem_addr`=SRC_BASE+2*i+1, `mem_rd`=1.
  - Latches `opB`.
  - Goes to CALC.
- CALC:
  - `calc_req`=1 and held.
  - When `calc_ack`=1, latches `res_msw`/`res_lsw` into internal registers and goes to WR_MSW.
  - Otherwise stays in CALC.
- WR_MSW: `mem_addr`=DST_BASE+2*i, `mem_wr`=1, `mem_din`=latched MSW.
- WR_LSW:
  - `mem_addr`=DST_BASE+2*i+1, `mem_wr`=1, `mem_din`=latched LSW.
  - If i==N_PAIRS-1, goes to DONE.
  - Otherwise increments i and goes to RD_A.
- DONE: `halt`=1, all enables 0. Stays in DONE until `start`.
- Address arithmetic is modulo 2^AW; addresses wrap silently (e.g. 255+1 -> 0).
- `calc_ack` outside CALC is ignored.
- `mem_rd` and `mem_wr` are never high together.
- `pair_ct`=i.
- `opA`/`opB` hold their values outside the RD states.

## Timing
- All outputs are Moore outputs decoded from registered state, the pair counter and data registers. There is no combinational input-to-output path.
- Reset values, applied immediately on `start` (asynchronous):
  - state=IDLE.
  - `mem_addr`=0, `mem_rd`=0, `mem_wr`=0, `mem_din`=0.
  - `opA`=0, `opB`=0, `calc_req`=0.
  - `pair_ct`=0, `halt`=0, `err`=0.
- Edge numbering: posedge 1 is the first posedge after `start` falls; it leaves IDLE.
- A pair takes 4+k cycles, where k≥1 is the CALC dwell (ack in the k-th CALC cycle).
- With k=1 for every pair, `halt` rises after edge 1+5*N_PAIRS.
- Handshake: `calc_req` falls in the cycle after ack is sampled. The multiplier must not pulse `calc_ack` again before a new rising `calc_req`.
- Reset mid-operation:
  - Any in-progress write is dropped combinationally.
  - The sequence restarts from pair 0.
  - Memory already written is not restored.

## Configuration
- `MUL_SEQ_TIMEOUT_EN` defined:
  - A CALC-cycle counter is compiled in.
  - If `CALC_TIMEOUT` CALC cycles elapse without ack, `err`=1 and the block goes to DONE (`halt`=1).
  - No writes occur for the failing pair.
  - Counter clears on entry to CALC.
- `MUL_SEQ_TIMEOUT_EN` undefined:
  - No counter; CALC waits indefinitely.
  - `err` is tied 0.

## Test plan
- mem[0]=3, mem[1]=5, N_PAIRS=1, stub acks in first CALC cycle (product 15) -> mem[30]=0x00, mem[31]=0x0F; `halt` rises after edge 6.
- N_PAIRS=2, pairs (0xFF,0xFF) and (0x10,0x10), ack on 3rd CALC cycle -> mem[30..33]=0xFE,0x01,0x01,0x00; `halt` after edge 15.
- `start` pulsed while `calc_req`=1 -> `calc_req`, `mem_wr`, `pair_ct` drop to 0 the same cycle; after release, RD_A re-reads address SRC_BASE.
- Spurious `calc_ack` pulses during RD_A, WR_MSW and DONE -> no state change, no extra `mem_wr`, write count stays 2*N_PAIRS.
- SRC_BASE=254, N_PAIRS=2 -> reads at 254, 255, 0, 1 in order; N_PAIRS=0 -> `halt` after edge 1, zero reads and writes.
- Timeout case, CALC_TIMEOUT=8, no ack:
  - With `MUL_SEQ_TIMEOUT_EN` -> `err`=1 and `halt`=1 after 8 CALC cycles; `mem_wr` never asserted.
  - Without it -> `halt` stays 0 for 1000 cycles.
